dma_chnl_seq: RTL

DMA channel sequencer between the APB CSR file and one read or write DMA engine. It latches a descriptor (base address, burst length, loop count, stride, channel) on a run pulse. It then issues `loop` bursts at `baddr + i*stride` to the engine over a req/ack command port and tracks outstanding completions. It reports ready/done/error/irq back to the CSR file. One instance serves the read side (`csr_r_*`) and one serves the write side (`csr_w_*`).

---
 rtl/dma_chnl_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dma_chnl_seq.sv
// DMA channel sequencer: latches a descriptor on csr_run, issues csr_loop
// bursts at baddr + i*stride over a req/ack command port, limits the number
// of bursts in flight to OUTSTD and reports done/error/irq to the CSR file.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for csr_run; csr_ready high
// ISSUE | issuing bursts while issued < loop and capacity is free
// DRAIN | all bursts issued (or engine error); waiting for outst == 0
module dma_chnl_seq #(
    parameter int OUTSTD = 4,
    parameter int AW     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] csr_baddr,
    input  logic [AW-1:0] csr_len,
    input  logic [31:0]   csr_loop,
    input  logic [AW-1:0] csr_stride,
    input  logic [3:0]    csr_chnl,
    input  logic          csr_run,
    input  logic          csr_irq_clr,
    output logic          csr_ready,
    output logic          csr_done,
    output logic [2:0]    csr_error,
    output logic          irq,
    output logic          burst_req,
    output logic [AW-1:0] burst_addr,
    output logic [AW-1:0] burst_len,
    output logic [3:0]    burst_chnl,
    input  logic          burst_ack,
    input  logic          burst_cmpl,
    input  logic          burst_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] OUTSTD_L = 4'(OUTSTD);

    state_t        state;
    logic [31:0]   issued;
    logic [31:0]   loop_q;
    logic [AW-1:0] stride_q;
    logic [3:0]    outst;

    logic          acc;
    logic          cmpl_v;
    logic          eng_err;
    logic          cfg_bad;
    logic          finishing;
    logic [3:0]    outst_nxt;
    logic [31:0]   issued_nxt;

    // Request is a pure decode of registered state so it drops on reset at once.
    assign burst_req = (state == ISSUE) && (issued < loop_q) && (outst < OUTSTD_L);
    assign csr_ready = (state == IDLE);
    assign irq       = csr_done;

    // Next-value decode for the burst/completion counters and the finish condition.
    always_comb begin
        acc        = burst_req & burst_ack;
        // A completion with nothing in flight (e.g. a stray one after reset) is dropped.
        cmpl_v     = burst_cmpl & (outst != 4'd0);
        eng_err    = cmpl_v & burst_err & (state != IDLE);
        cfg_bad    = (csr_len == '0) || (csr_loop == 32'd0);
        outst_nxt  = outst + 4'(acc) - 4'(cmpl_v);
        issued_nxt = issued + 32'(acc);
        finishing  = (state != IDLE) && (outst_nxt == 4'd0) &&
                     ((state == DRAIN) || eng_err || (issued_nxt == loop_q));
    end

    // Sequencer FSM with descriptor latch, counters and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issued     <= 32'd0;
            loop_q     <= 32'd0;
            stride_q   <= '0;
            outst      <= 4'd0;
            burst_addr <= '0;
            burst_len  <= '0;
            burst_chnl <= 4'd0;
            csr_done   <= 1'b0;
            csr_error  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (csr_run) begin
                        loop_q     <= csr_loop;
                        stride_q   <= csr_stride;
                        burst_len  <= csr_len;
                        burst_chnl <= csr_chnl;
                        if (!cfg_bad) begin
                            state      <= ISSUE;
                            issued     <= 32'd0;
                            outst      <= 4'd0;
                            burst_addr <= csr_baddr;
                        end
                    end
                end
                ISSUE: begin
                    issued <= issued_nxt;
                    outst  <= outst_nxt;
                    if (acc) begin
                        burst_addr <= burst_addr + stride_q;
                    end
                    if (finishing) begin
                        state <= IDLE;
                    end else if (eng_err || (issued_nxt == loop_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    outst <= outst_nxt;
                    if (finishing) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An accepted run restarts the error record; otherwise errors accumulate.
            if ((state == IDLE) && csr_run) begin
                csr_error <= {2'b00, cfg_bad};
            end else begin
                csr_error <= csr_error |
                             {csr_run && (state != IDLE), eng_err, 1'b0};
            end

            // Done-set has priority over both the run clear and csr_irq_clr.
            if (((state == IDLE) && csr_run && cfg_bad) || finishing) begin
                csr_done <= 1'b1;
            end else if (((state == IDLE) && csr_run) || csr_irq_clr) begin
                csr_done <= 1'b0;
            end
        end
    end

endmodule
